pio_poll_master: RTL and testbench
==================================

# pio_poll_master

Avalon-MM read initiator that periodically polls a read-only PIO slave (4-bit input port behind a registered `readdata`), debounces the sampled value, and presents a stable value with a change strobe to fabric logic. It sits between a PIO slave's s1 port and hardware consumers, replacing Nios software polling of the challenge/mode select inputs. Poll rate and debounce depth are parameterised.

## Interface
- `DATA_W`, 4: significant low bits of `avm_readdata` captured; range 1..32.
- `ADDR_W`, 2: width of `avm_address`.
- `POLL_DIV`, 50000: clock cycles between poll requests; must be at least 8.
- `READ_LATENCY`, 1: fixed cycles from read acceptance to valid `avm_readdata`; must be at least 1.
- `STABLE_COUNT`, 3: consecutive identical samples required before accepting a new value; must be at least 1.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: polling enable.
- `avm_address`, out, ADDR_W: always 0, which is the data register.
- `avm_read`, out, 1: read request.
- `avm_waitrequest`, in, 1: slave stall.
- `avm_readdata`, in, 32: slave read data.
- `value`, out, DATA_W: debounced value.
- `value_valid`, out, 1: set when the first value is accepted; sticky until reset.
- `change_pulse`, out, 1: one-cycle strobe on every accepted value update.
- `overrun`, out, 1: one-cycle strobe when a poll tick is dropped.

## Operation
- **Reset values:**
  - `avm_read`, `value`, `value_valid`, `change_pulse`, `overrun` = 0.
  - State IDLE; tick counter 0; pending 0; candidate 0; match count 0.
- **Tick counter:**
  - Counts 0..POLL_DIV-1 while `enable` is high.
  - On wrap it sets `pending`.
  - While `enable` is low the counter holds at 0 and `pending` is cleared.
- **Dropped tick:** if a wrap occurs while `pending` is already set, or while the FSM is not IDLE, the tick is dropped and `overrun` pulses.
- **FSM states:**
  - IDLE: if `pending` is set, clear it and go to REQ.
  - REQ: `avm_read` = 1, `avm_address` = 0. Hold until an edge where `avm_waitrequest` is 0 (accepted), then go to WAIT and load the latency counter.
  - WAIT: count READ_LATENCY edges after acceptance. On the last one, capture `avm_readdata[DATA_W-1:0]` as `sample` and return to IDLE.
- **`avm_read` timing:** Moore output of REQ. It is never dropped before acceptance, even if `enable` falls or `pending` clears.
- **Debounce (evaluated on the capture edge):**
  - If `sample` == candidate, match count increments, saturating at STABLE_COUNT.
  - Otherwise candidate <= `sample` and match count <= 1.
- **Acceptance:**
  - Condition: the new match count equals STABLE_COUNT, and either `value_valid` is 0 or candidate differs from `value`.
  - Action: `value` <= candidate, `value_valid` <= 1, `change_pulse` <= 1 for one cycle.
  - When STABLE_COUNT = 1, every changed sample is accepted immediately.
- **Enable deasserted mid-transaction:** the transaction completes and its sample is still evaluated; no further requests issue.
- **Upper `avm_readdata` bits:** ignored.
- **Asynchronous reset mid-transaction:** immediate return to reset values. The slave-side read is abandoned; the Avalon fabric tolerates this only under a global reset.

## Timing
- **Zero-stall poll, READ_LATENCY = 1:**
  - Edge E0: wrap sets `pending`.
  - Edge E1: enter REQ; `avm_read` high in the following cycle.
  - Edge E2: accepted.
  - Edge E3: capture.
  - `change_pulse` / `value` update visible in the cycle after E3.
  - Total: 3 edges from pending to capture, plus READ_LATENCY-1 per extra latency cycle, plus one per waitrequest stall cycle.
- **Poll period:** exactly POLL_DIV cycles between `pending` set events while `enable` stays high.
- **Minimum first-acceptance time after enable:** STABLE_COUNT × POLL_DIV + 3 cycles (READ_LATENCY = 1, no stalls).
- **Strobes:** `change_pulse` and `overrun` are registered, one cycle wide, and never stretched. Both may assert in the same cycle.

## Test plan
- **Basic poll.** POLL_DIV = 8, STABLE_COUNT = 3, slave in_port = 4'hA, `enable` = 1.
  - Required: `avm_read` pulses with period 8 and address 0.
  - Required: `value` = 4'hA, `value_valid` = 1 and a single `change_pulse` after the 3rd capture. No further pulses while the input is constant.
- **Glitch rejection.** in_port sequence A, A, 5, A, A, A across polls after 4'hA is accepted.
  - Required: `value` stays 4'hA and `change_pulse` never asserts.
  - Then 5, 5, 5 → `value` = 4'h5 with one pulse on the 3rd capture.
- **Waitrequest stall.** Hold `avm_waitrequest` = 1 for 4 cycles during REQ.
  - Required: `avm_read` stays high with stable address until acceptance.
  - Required: capture exactly READ_LATENCY edges after acceptance (also run with READ_LATENCY = 3 and verify the correct word is captured).
- **Overrun.** POLL_DIV = 8, waitrequest held high for 10 cycles.
  - Required: `overrun` pulses once per dropped wrap.
  - Required: exactly one read per accepted `pending`, with no back-to-back duplicate requests.
- **Enable drop.** Deassert `enable` in the cycle after `avm_read` rises, with waitrequest = 1 for 2 cycles.
  - Required: the read completes and its sample is evaluated; the tick counter is 0; no new `avm_read` until `enable` returns.
- **Reset mid-transaction.** Pulse `reset_n` low during WAIT.
  - Required: all outputs drop to 0 asynchronously.
  - Required: after release, polling restarts from count 0 and `value_valid` re-acquires only after STABLE_COUNT samples.

Source files
------------

// File: rtl/pio_poll_master.sv
// pio_poll_master: periodically reads a read-only PIO data register over
// Avalon-MM, debounces the low DATA_W bits and presents a stable value with
// a one-cycle change strobe and a dropped-tick (overrun) strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; a pending poll tick launches a read
// REQ     | avm_read held high until the slave drops waitrequest
// WAIT    | counting READ_LATENCY edges; readdata captured on the last
module pio_poll_master #(
   parameter int DATA_W       = 4,
   parameter int ADDR_W       = 2,
   parameter int POLL_DIV     = 50000,
   parameter int READ_LATENCY = 1,
   parameter int STABLE_COUNT = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] value,
   output logic              value_valid,
   output logic              change_pulse,
   output logic              overrun
);

   localparam int TICK_W  = $clog2(POLL_DIV);
   localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int MATCH_W = $clog2(STABLE_COUNT + 1);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(POLL_DIV - 1);
   localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
   localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(STABLE_COUNT);
   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                pending_q, pending_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [DATA_W-1:0]   cand_q, cand_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic                value_valid_q, value_valid_d;
   logic                change_pulse_q, change_pulse_d;
   logic                overrun_q, overrun_d;
   logic                avm_read_q, avm_read_d;

   logic                wrap;
   logic                capture;
   logic [DATA_W-1:0]   sample;
   logic                unused_rdata;

   // Upper readdata bits carry nothing for a narrow PIO port.
   assign unused_rdata = &{1'b0, avm_readdata};
   assign sample       = avm_readdata[DATA_W-1:0];

   // Next-state logic: poll tick, request FSM, and debounce/acceptance.
   always_comb begin
      state_d        = state_q;
      tick_d         = tick_q;
      pending_d      = pending_q;
      lat_d          = lat_q;
      cand_d         = cand_q;
      match_d        = match_q;
      value_d        = value_q;
      value_valid_d  = value_valid_q;
      change_pulse_d = 1'b0;
      overrun_d      = 1'b0;
      wrap           = 1'b0;
      capture        = 1'b0;

      if (!enable) begin
         tick_d    = '0;
         pending_d = 1'b0;
      end else if (tick_q == TICK_LAST) begin
         tick_d = '0;
         wrap   = 1'b1;
      end else begin
         tick_d = tick_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               pending_d = 1'b0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!avm_waitrequest) begin
               lat_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A tick that arrives while one is still queued or in flight is lost.
      if (wrap) begin
         if (pending_q || (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (capture) begin
         if (sample == cand_q) begin
            match_d = (match_q == MATCH_FULL) ? MATCH_FULL : match_q + 1'b1;
         end else begin
            cand_d  = sample;
            match_d = MATCH_ONE;
         end
         if ((match_d == MATCH_FULL) && (!value_valid_q || (cand_d != value_q))) begin
            value_d        = cand_d;
            value_valid_d  = 1'b1;
            change_pulse_d = 1'b1;
         end
      end

      avm_read_d = (state_d == ST_REQ);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         tick_q         <= '0;
         pending_q      <= 1'b0;
         lat_q          <= '0;
         cand_q         <= '0;
         match_q        <= '0;
         value_q        <= '0;
         value_valid_q  <= 1'b0;
         change_pulse_q <= 1'b0;
         overrun_q      <= 1'b0;
         avm_read_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_q         <= tick_d;
         pending_q      <= pending_d;
         lat_q          <= lat_d;
         cand_q         <= cand_d;
         match_q        <= match_d;
         value_q        <= value_d;
         value_valid_q  <= value_valid_d;
         change_pulse_q <= change_pulse_d;
         overrun_q      <= overrun_d;
         avm_read_q     <= avm_read_d;
      end
   end

   assign avm_address  = '0;
   assign avm_read     = avm_read_q;
   assign value        = value_q;
   assign value_valid  = value_valid_q;
   assign change_pulse = change_pulse_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: two instances (read latency 1 and 3) with
// POLL_DIV = 8 and STABLE_COUNT = 3, each behind a small pipelined slave that
// returns junk outside the valid readdata cycle.
module tb_pio_poll_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable1, waitreq1, enable3, waitreq3;
   logic [3:0]  in1, in3;

   logic [1:0]  addr1, addr3;
   logic        read1, read3;
   logic [31:0] rdata1, rdata3;
   logic [3:0]  value1, value3;
   logic        valid1, valid3, chg1, chg3, ovr1, ovr3;

   logic        pipe1;
   logic [2:0]  pipe3;

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   pio_poll_master #(
      .DATA_W(4), .ADDR_W(2), .POLL_DIV(8), .READ_LATENCY(1), .STABLE_COUNT(3)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable1),
      .avm_address(addr1), .avm_read(read1), .avm_waitrequest(waitreq1),
      .avm_readdata(rdata1), .value(value1), .value_valid(valid1),
      .change_pulse(chg1), .overrun(ovr1)
   );

   pio_poll_master #(
      .DATA_W(4), .ADDR_W(2), .POLL_DIV(8), .READ_LATENCY(3), .STABLE_COUNT(3)
   ) u_dut3 (
      .clk(clk), .reset_n(reset_n), .enable(enable3),
      .avm_address(addr3), .avm_read(read3), .avm_waitrequest(waitreq3),
      .avm_readdata(rdata3), .value(value3), .value_valid(valid3),
      .change_pulse(chg3), .overrun(ovr3)
   );

   always #5 clk = ~clk;

   // Edge counter: cyc == k at the negedge following the k-th edge after reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // Slave models: readdata is valid only exactly READ_LATENCY edges after acceptance.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe1 <= 1'b0;
         pipe3 <= '0;
      end else begin
         pipe1 <= read1 && !waitreq1;
         pipe3 <= {pipe3[1:0], read3 && !waitreq3};
      end
   end
   assign rdata1 = pipe1    ? {28'hC0FFEE5, in1} : 32'h1234_567F;
   assign rdata3 = pipe3[2] ? {28'hDEADBEE, in3} : 32'h7654_3219;

   int   rd_rise[$];
   int   rd_len[$];
   int   rd3_rise[$];
   int   rd_cur, chg_cnt, ovr_cnt, ovr_last, addr_bad, chg3_cnt, ovr3_cnt;
   logic rd_prev, rd3_prev;

   // Event monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (read1 && !rd_prev) begin
         rd_rise.push_back(cyc);
         rd_cur = 0;
      end
      if (read1) rd_cur++;
      if (!read1 && rd_prev) rd_len.push_back(rd_cur);
      if ((read1 && addr1 != 2'd0) || (read3 && addr3 != 2'd0)) addr_bad++;
      if (chg1) chg_cnt++;
      if (ovr1) begin
         ovr_cnt++;
         ovr_last = cyc;
      end
      rd_prev = read1;
      if (read3 && !rd3_prev) rd3_rise.push_back(cyc);
      if (chg3) chg3_cnt++;
      if (ovr3) ovr3_cnt++;
      rd3_prev = read3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      @(negedge clk);
      while (cyc != n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (cyc != n) chk("wait_timeout", cyc, n);
   endtask

   task automatic clear_mon();
      rd_rise.delete();
      rd_len.delete();
      rd3_rise.delete();
      rd_cur   = 0;
      chg_cnt  = 0;
      ovr_cnt  = 0;
      ovr_last = 0;
      chg3_cnt = 0;
      ovr3_cnt = 0;
      rd_prev  = 1'b0;
      rd3_prev = 1'b0;
   endtask

   initial begin
      addr_bad = 0;
      clear_mon();
      reset_n  = 1'b0;
      enable1  = 1'b1;
      waitreq1 = 1'b0;
      in1      = 4'hA;
      enable3  = 1'b0;
      waitreq3 = 1'b0;
      in3      = 4'h6;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_read",  read1,  0);
      chk("rst_value", value1, 0);
      chk("rst_valid", valid1, 0);
      chk("rst_chg",   chg1,   0);
      chk("rst_ovr",   ovr1,   0);
      reset_n = 1'b1;

      // Basic poll: first accept after the third capture (edge 27).
      wait_cyc(26);
      chk("basic_valid_early", valid1, 0);
      wait_cyc(27);
      chk("basic_chg",   chg1,   1);
      chk("basic_value", value1, 4'hA);
      chk("basic_valid", valid1, 1);
      wait_cyc(28);
      chk("basic_chg_width", chg1, 0);

      // Glitch rejection, then a real change to 5 on capture 12 (edge 99).
      wait_cyc(44);
      in1 = 4'h5;
      wait_cyc(52);
      in1 = 4'hA;
      wait_cyc(76);
      in1 = 4'h5;
      wait_cyc(98);
      chk("glitch_value", value1, 4'hA);
      chk("glitch_chg_cnt", chg_cnt, 1);
      wait_cyc(99);
      chk("change5_pulse", chg1, 1);
      chk("change5_value", value1, 4'h5);
      wait_cyc(100);
      chk("change5_cnt", chg_cnt, 2);
      in1 = 4'h3;

      // Waitrequest stall of 4 cycles on the read launched at edge 105.
      wait_cyc(105);
      chk("stall_read_rise", read1, 1);
      waitreq1 = 1'b1;
      wait_cyc(109);
      chk("stall_read_held", read1, 1);
      waitreq1 = 1'b0;
      wait_cyc(110);
      chk("stall_read_drop", read1, 0);
      wait_cyc(123);
      chk("stall_capture_chg", chg1, 1);
      chk("stall_capture_value", value1, 4'h3);

      // Overrun: 10-cycle stall swallows the wrap at edge 136.
      wait_cyc(129);
      chk("ovr_read_rise", read1, 1);
      waitreq1 = 1'b1;
      wait_cyc(136);
      chk("ovr_pulse", ovr1, 1);
      wait_cyc(137);
      chk("ovr_width", ovr1, 0);
      wait_cyc(139);
      waitreq1 = 1'b0;
      wait_cyc(142);
      chk("ovr_cnt", ovr_cnt, 1);
      chk("ovr_cycle", ovr_last, 136);
      in1 = 4'hC;

      // Enable drop one cycle after the read rises, 2-cycle stall.
      wait_cyc(145);
      chk("endrop_read_rise", read1, 1);
      enable1  = 1'b0;
      waitreq1 = 1'b1;
      wait_cyc(147);
      waitreq1 = 1'b0;
      wait_cyc(150);
      chk("endrop_tick",  u_dut.tick_q,  0);
      chk("endrop_cand",  u_dut.cand_q,  4'hC);
      chk("endrop_match", u_dut.match_q, 1);
      in1 = 4'h3;
      wait_cyc(180);
      chk("read_count", rd_rise.size(), 17);
      chk("rise_0",  rd_rise[0],  9);
      chk("rise_1",  rd_rise[1],  17);
      chk("rise_15", rd_rise[15], 129);
      chk("rise_16", rd_rise[16], 145);
      chk("len_stall4",  rd_len[12], 5);
      chk("len_stall10", rd_len[15], 11);
      chk("len_endrop",  rd_len[16], 3);
      chk("chg_total", chg_cnt, 3);
      chk("ovr_total", ovr_cnt, 1);
      enable1 = 1'b1;
      wait_cyc(189);
      chk("reenable_rise", rd_rise[17], 189);

      // Asynchronous reset while in WAIT.
      wait_cyc(190);
      chk("pre_rst_value", value1, 4'h3);
      chk("pre_rst_valid", valid1, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_read",  read1,  0);
      chk("arst_value", value1, 0);
      chk("arst_valid", valid1, 0);
      chk("arst_chg",   chg1,   0);
      chk("arst_ovr",   ovr1,   0);
      @(negedge clk);
      #1;
      clear_mon();
      enable3 = 1'b1;
      reset_n = 1'b1;

      // Restart: both instances poll from count 0; latency-3 one stalls first read.
      wait_cyc(9);
      chk("restart_rise", rd_rise[0], 9);
      chk("l3_read_rise", read3, 1);
      waitreq3 = 1'b1;
      wait_cyc(13);
      chk("l3_read_held", read3, 1);
      waitreq3 = 1'b0;
      wait_cyc(14);
      chk("l3_read_drop", read3, 0);
      wait_cyc(16);
      chk("l3_ovr", ovr3, 1);
      wait_cyc(26);
      chk("reacq_valid_early", valid1, 0);
      wait_cyc(27);
      chk("reacq_valid", valid1, 1);
      chk("reacq_value", value1, 4'h3);
      wait_cyc(36);
      chk("l3_valid_early", valid3, 0);
      wait_cyc(37);
      chk("l3_chg",   chg3,   1);
      chk("l3_value", value3, 4'h6);
      wait_cyc(40);
      chk("l3_read_count", rd3_rise.size(), 3);
      chk("l3_rise_1", rd3_rise[1], 25);
      chk("l3_rise_2", rd3_rise[2], 33);
      chk("l3_chg_cnt", chg3_cnt, 1);
      chk("l3_ovr_cnt", ovr3_cnt, 1);
      chk("addr_zero", addr_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
